// File: rtl/display_timing.sv
// Raster timing generator: free-running pixel/line counters with registered
// sync, data-enable, fetch-ahead and frame-start decodes, all aligned to (h, v).
module display_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out,
  output logic          fetch_out,
  output logic [HW-1:0] x_out,
  output logic [VW-1:0] y_out,
  output logic          line_start_out,
  output logic          frame_start_out,
  output logic [7:0]    frame_count_out
);

  if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_params
    $error("display_timing: every timing parameter must be non-zero");
  end

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h, h_nxt, h_nn;
  logic [VW-1:0] v, v_nxt, v_nn;
  logic          first;

  // Next position and the one after it; fetch looks two steps ahead of (h, v)
  // because it is registered and must lead de_out by one cycle.
  always_comb begin
    h_nxt = (h == H_LAST) ? '0 : h + HW'(1);
    v_nxt = v;
    if (h == H_LAST) v_nxt = (v == V_LAST) ? '0 : v + VW'(1);
    h_nn = (h_nxt == H_LAST) ? '0 : h_nxt + HW'(1);
    v_nn = v_nxt;
    if (h_nxt == H_LAST) v_nn = (v_nxt == V_LAST) ? '0 : v_nxt + VW'(1);
  end

  assign x_out = h;
  assign y_out = v;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      h               <= H_LAST;
      v               <= V_LAST;
      de_out          <= 1'b0;
      fetch_out       <= 1'b1;
      hsync_out       <= ~H_POL;
      vsync_out       <= ~V_POL;
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
      frame_count_out <= 8'd0;
      first           <= 1'b1;
    end else begin
      h               <= h_nxt;
      v               <= v_nxt;
      de_out          <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
      fetch_out       <= (h_nn < H_ACT_END) && (v_nn < V_ACT_END);
      hsync_out       <= ((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END)) ? H_POL : ~H_POL;
      vsync_out       <= ((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END)) ? V_POL : ~V_POL;
      line_start_out  <= (h_nxt == '0);
      frame_start_out <= (h_nxt == '0) && (v_nxt == '0);
      first           <= 1'b0;
      // The wrap straight out of reset starts the first frame; it completes none.
      if ((h_nxt == '0) && (v_nxt == '0) && !first)
        frame_count_out <= frame_count_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: a small high-polarity instance (7 x 5 raster) for
// full-frame and wrap behaviour, and a default 640x480 instance for line timing.
module tb_display_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, rst_d;
  logic       s_hs, s_vs, s_de, s_fe, s_ls, s_fs;
  logic [2:0] s_x, s_y;
  logic [7:0] s_fc;
  logic       d_hs, d_vs, d_de, d_fe, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;

  display_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_small (
    .clk_in(clk), .rst_in(rst_s), .hsync_out(s_hs), .vsync_out(s_vs),
    .de_out(s_de), .fetch_out(s_fe), .x_out(s_x), .y_out(s_y),
    .line_start_out(s_ls), .frame_start_out(s_fs), .frame_count_out(s_fc)
  );

  display_timing dut_def (
    .clk_in(clk), .rst_in(rst_d), .hsync_out(d_hs), .vsync_out(d_vs),
    .de_out(d_de), .fetch_out(d_fe), .x_out(d_x), .y_out(d_y),
    .line_start_out(d_ls), .frame_start_out(d_fs), .frame_count_out(d_fc)
  );

  typedef struct {
    logic [2:0] x, y;
    logic       de, hs, vs, fe, ls, fs;
    logic [7:0] fc;
  } exp_t;

  typedef struct {
    logic rst;
    exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic rst);
    rst_s = rst;
    tick();
  endtask

  function automatic exp_t mk(input int x, input int y, input logic de, input logic hs,
                              input logic vs, input logic fe, input logic ls,
                              input logic fs, input int fc);
    exp_t e;
    e.x = 3'(x); e.y = 3'(y); e.de = de; e.hs = hs; e.vs = vs;
    e.fe = fe; e.ls = ls; e.fs = fs; e.fc = 8'(fc);
    return e;
  endfunction

  // Position-based reference for the 7 x 5 raster (active 4/2, sync at h=5, v=3).
  function automatic exp_t small_model(input int h, input int v, input int fc);
    exp_t e;
    int nh, nv;
    nh = (h == 6) ? 0 : h + 1;
    nv = (h == 6) ? ((v == 4) ? 0 : v + 1) : v;
    e.x = 3'(h); e.y = 3'(v);
    e.de = (h < 4) && (v < 2);
    e.hs = (h == 5);
    e.vs = (v == 3);
    e.fe = (nh < 4) && (nv < 2);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    e.fc = 8'(fc);
    return e;
  endfunction

  task automatic check_small(input string tag, input exp_t e);
    check_output({tag, "_x"},  32'(s_x),  32'(e.x));
    check_output({tag, "_y"},  32'(s_y),  32'(e.y));
    check_output({tag, "_de"}, 32'(s_de), 32'(e.de));
    check_output({tag, "_hs"}, 32'(s_hs), 32'(e.hs));
    check_output({tag, "_vs"}, 32'(s_vs), 32'(e.vs));
    check_output({tag, "_fe"}, 32'(s_fe), 32'(e.fe));
    check_output({tag, "_ls"}, 32'(s_ls), 32'(e.ls));
    check_output({tag, "_fs"}, 32'(s_fs), 32'(e.fs));
    check_output({tag, "_fc"}, 32'(s_fc), 32'(e.fc));
  endtask

  vec_t tab[10];

  initial begin
    int mh, mv, mfc, nh, nv, cnt;
    int de_run, hs_low, hs_first, hs_last, line_len, fe_mis;
    logic prev_fe, prev_fc_255, seen_wrap, found;
    exp_t rst_exp;

    rst_exp = mk(6, 4, 0, 0, 0, 1, 0, 0, 0);
    tab[0] = '{1'b1, rst_exp};
    tab[1] = '{1'b1, rst_exp};
    tab[2] = '{1'b0, mk(0, 0, 1, 0, 0, 1, 1, 1, 0)};
    tab[3] = '{1'b0, mk(1, 0, 1, 0, 0, 1, 0, 0, 0)};
    tab[4] = '{1'b0, mk(2, 0, 1, 0, 0, 1, 0, 0, 0)};
    tab[5] = '{1'b0, mk(3, 0, 1, 0, 0, 0, 0, 0, 0)};
    tab[6] = '{1'b0, mk(4, 0, 0, 0, 0, 0, 0, 0, 0)};
    tab[7] = '{1'b0, mk(5, 0, 0, 1, 0, 0, 0, 0, 0)};
    tab[8] = '{1'b0, mk(6, 0, 0, 0, 0, 1, 0, 0, 0)};
    tab[9] = '{1'b0, mk(0, 1, 1, 0, 0, 1, 1, 0, 0)};

    rst_s = 1'b1;
    rst_d = 1'b1;
    tick();
    tick();

    // Default instance: reset state, release, then two full lines.
    check_output("def_rst_x",  32'(d_x),  32'd799);
    check_output("def_rst_y",  32'(d_y),  32'd524);
    check_output("def_rst_de", 32'(d_de), 32'd0);
    check_output("def_rst_hs", 32'(d_hs), 32'd1);
    check_output("def_rst_vs", 32'(d_vs), 32'd1);
    check_output("def_rst_fe", 32'(d_fe), 32'd1);
    check_output("def_rst_ls", 32'(d_ls), 32'd0);
    check_output("def_rst_fs", 32'(d_fs), 32'd0);
    check_output("def_rst_fc", 32'(d_fc), 32'd0);
    rst_d = 1'b0;
    tick();
    check_output("def_start_x",  32'(d_x),  32'd0);
    check_output("def_start_y",  32'(d_y),  32'd0);
    check_output("def_start_de", 32'(d_de), 32'd1);
    check_output("def_start_ls", 32'(d_ls), 32'd1);
    check_output("def_start_fs", 32'(d_fs), 32'd1);
    check_output("def_start_fc", 32'(d_fc), 32'd0);

    mh = 0; mv = 0;
    de_run = 0; hs_low = 0; hs_first = -1; hs_last = -1; line_len = 0; fe_mis = 0;
    prev_fe = d_fe;
    for (int i = 0; i < 1700; i++) begin
      nh = (mh == 799) ? 0 : mh + 1;
      nv = (mh == 799) ? mv + 1 : mv;
      check_output("def_x",  32'(d_x),  32'(mh));
      check_output("def_y",  32'(d_y),  32'(mv));
      check_output("def_de", 32'(d_de), 32'((mh < 640) && (mv < 480)));
      check_output("def_hs", 32'(d_hs), 32'(!((mh >= 656) && (mh < 752))));
      check_output("def_fe", 32'(d_fe), 32'((nh < 640) && (nv < 480)));
      if (i > 0 && prev_fe !== d_de) fe_mis++;
      if (mv == 0 && d_de === 1'b1) de_run++;
      if (mv == 0 && d_hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
      end
      if (i > 0 && d_ls === 1'b1 && line_len == 0) line_len = i;
      prev_fe = d_fe;
      mh = nh; mv = nv;
      tick();
    end
    check_output("def_de_run",   32'(de_run),   32'd640);
    check_output("def_hs_low",   32'(hs_low),   32'd96);
    check_output("def_hs_first", 32'(hs_first), 32'd656);
    check_output("def_hs_last",  32'(hs_last),  32'd751);
    check_output("def_line_len", 32'(line_len), 32'd800);
    check_output("def_fe_vs_de", 32'(fe_mis),   32'd0);

    // Small instance: table of hand-computed vectors through reset and line 0.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tab[i].rst);
      check_small($sformatf("vec%0d", i), tab[i].e);
    end

    // Then every cycle against the model for more than 256 frames.
    mh = 0; mv = 1; mfc = 0;
    seen_wrap = 1'b0;
    prev_fc_255 = 1'b0;
    for (int n = 0; n < 256 * 35 + 34; n++) begin
      if (mh == 6) begin
        mh = 0;
        if (mv == 4) begin mv = 0; mfc = (mfc + 1) % 256; end
        else mv = mv + 1;
      end else mh = mh + 1;
      tick();
      check_small("run", small_model(mh, mv, mfc));
      if (prev_fc_255 && s_fc === 8'd0) seen_wrap = 1'b1;
      prev_fc_255 = (s_fc === 8'd255);
    end
    check_output("fc_wrap_seen", 32'(seen_wrap), 32'd1);

    // Line and frame periods measured between start pulses.
    cnt = 0;
    while (s_ls !== 1'b1 && cnt < 10) begin tick(); cnt++; end
    check_output("ls_found", 32'(s_ls), 32'd1);
    cnt = 0;
    do begin tick(); cnt++; end while (s_ls !== 1'b1 && cnt < 20);
    check_output("line_period", 32'(cnt), 32'd7);
    cnt = 0;
    while (s_fs !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    check_output("fs_found", 32'(s_fs), 32'd1);
    cnt = 0;
    do begin tick(); cnt++; end while (s_fs !== 1'b1 && cnt < 80);
    check_output("frame_period", 32'(cnt), 32'd35);

    // Mid-frame reset at (3, 2): frame abandoned, counters restart cleanly.
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (s_x === 3'd3 && s_y === 3'd2) found = 1'b1;
      else tick();
    end
    check_output("midrst_pos_found", 32'(found), 32'd1);
    apply_stimulus(1'b1);
    check_small("midrst", rst_exp);
    apply_stimulus(1'b0);
    check_small("restart", mk(0, 0, 1, 0, 0, 1, 1, 1, 0));
    apply_stimulus(1'b0);
    check_small("restart1", mk(1, 0, 1, 0, 0, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
